// File: rtl/diff_accumulator.sv
// diff_accumulator: sums COUNT consecutive signed differences from the
// Subtractor stage into a signed ACC_WIDTH block sum. The result is handed off
// over a valid/ready handshake together with a sticky overflow flag.
// Optional build macro: DIFF_ACC_SATURATE_EN
//   defined   -> on signed overflow the running sum clamps to the ACC_WIDTH
//                limits, and later adds continue from the clamped value.
//   undefined -> the running sum wraps modulo 2^ACC_WIDTH.
// In both builds out_ovf reports any overflow that occurred within the block.
module diff_accumulator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned COUNT     = 4,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [WIDTH:0]       in_diff,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned      CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam int unsigned      MSB      = ACC_WIDTH - 1;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_acc_q, ovf_acc_d;
  logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic                   out_ovf_q, out_ovf_d;
  logic                   out_valid_q, out_valid_d;

  logic [ACC_WIDTH-1:0]   x_ext;
  logic [ACC_WIDTH-1:0]   sum_raw;
  logic [ACC_WIDTH-1:0]   sum_add;
  logic                   ovf_add;
  logic                   accept;

  // in_ready depends only on registered state, so there is no path from out_ready
  assign in_ready  = (state_q == ST_ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

  // Sign-extend the sample, add it to the running sum and detect signed overflow
  always_comb begin
    x_ext   = ACC_WIDTH'($signed(in_diff));
    sum_raw = acc_q + x_ext;
    ovf_add = (acc_q[MSB] == x_ext[MSB]) && (sum_raw[MSB] != acc_q[MSB]);
  end

`ifdef DIFF_ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Clamp toward the sign of the operands; both operands share it when overflow occurs
  always_comb begin
    sum_add = sum_raw;
    if (ovf_add) begin
      sum_add = acc_q[MSB] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  // Wrap-around build: the raw modulo-2^ACC_WIDTH sum is used unchanged
  always_comb begin
    sum_add = sum_raw;
  end
`endif

  // Next-state logic: clear has priority over both handshakes
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      state_d     = ST_ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_acc_d   = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            if (cnt_q == CNT_LAST) begin
              out_sum_d   = sum_add;
              out_ovf_d   = ovf_acc_q | ovf_add;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_acc_d   = 1'b0;
              state_d     = ST_OUTPUT;
            end else begin
              acc_d       = sum_add;
              cnt_d       = cnt_q + CNT_W'(1);
              ovf_acc_d   = ovf_acc_q | ovf_add;
            end
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACCUM;
          end
        end
        default: begin
          state_d     = ST_ACCUM;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_diff_accumulator.sv
// Directed bench for diff_accumulator. Two instances share all inputs:
// u_dut16 (ACC_WIDTH=16) and u_dut10 (ACC_WIDTH=10). The narrow instance
// exercises overflow. Expected values are hand-computed, or come from an
// integer reference for the random stream.
module tb_diff_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [8:0]  in_diff;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready16, out_ovf16, out_valid16;
  logic [15:0] out_sum16;
  logic        in_ready10, out_ovf10, out_valid10;
  logic [9:0]  out_sum10;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  diff_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_diff(in_diff), .in_valid(in_valid), .in_ready(in_ready16),
    .out_sum(out_sum16), .out_ovf(out_ovf16), .out_valid(out_valid16),
    .out_ready(out_ready)
  );

  diff_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_diff(in_diff), .in_valid(in_valid), .in_ready(in_ready10),
    .out_sum(out_sum10), .out_ovf(out_ovf10), .out_valid(out_valid10),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until it is accepted, with a bounded wait
  task automatic send(input logic [8:0] v);
    int unsigned n;
    n = 0;
    in_diff  = v;
    in_valid = 1'b1;
    while (!in_ready16 && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", {31'd0, in_ready16}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_block(input string tag, input logic [15:0] e16, input logic o16,
                              input logic [9:0] e10, input logic o10);
    check({tag, "_valid16"}, {31'd0, out_valid16}, 32'd1);
    check({tag, "_valid10"}, {31'd0, out_valid10}, 32'd1);
    check({tag, "_sum16"},   {16'd0, out_sum16},   {16'd0, e16});
    check({tag, "_ovf16"},   {31'd0, out_ovf16},   {31'd0, o16});
    check({tag, "_sum10"},   {22'd0, out_sum10},   {22'd0, e10});
    check({tag, "_ovf10"},   {31'd0, out_ovf10},   {31'd0, o10});
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_pop_valid"}, {31'd0, out_valid16}, 32'd0);
    check({tag, "_pop_ready"}, {31'd0, in_ready16},  32'd1);
  endtask

  // Reference add for a signed range [lo,hi]; reports overflow, then wraps or clamps
  function automatic int ref_add(input int acc, input int x, input int lo, input int hi,
                                 output bit ovf);
    int s;
    s   = acc + x;
    ovf = (s > hi) || (s < lo);
`ifdef DIFF_ACC_SATURATE_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`else
    if (s > hi) s = s - (hi - lo + 1);
    if (s < lo) s = s + (hi - lo + 1);
`endif
    return s;
  endfunction

  initial begin
    int a, b, x;
    int acc16, acc10;
    bit ov, ovb16, ovb10;
    logic [15:0] e16;
    logic [9:0]  e10;

    rst_n = 1'b0; clear = 1'b0; in_diff = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", {31'd0, out_valid16}, 32'd0);
    check("rst_sum",   {16'd0, out_sum16},   32'd0);
    check("rst_ovf",   {31'd0, out_ovf16},   32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready16}, 32'd1);

    // Test 1: 10, -5, 3, -255 back to back; -247 = 16'hFF09 = 10'h309
    send(9'd10); send(9'h1FB); send(9'd3);
    check("t1_latency", {31'd0, out_valid16}, 32'd0);
    send(9'h101);
    expect_block("t1", 16'hFF09, 1'b0, 10'h309, 1'b0);
    check("t1_in_ready_low", {31'd0, in_ready16}, 32'd0);
    pop("t1");

    // Test 2: four +255 then four -255
    send(9'h0FF); send(9'h0FF); send(9'h0FF); send(9'h0FF);
`ifdef DIFF_ACC_SATURATE_EN
    expect_block("t2p", 16'h03FC, 1'b0, 10'h1FF, 1'b1);
`else
    expect_block("t2p", 16'h03FC, 1'b0, 10'h3FC, 1'b1);
`endif
    pop("t2p");
    send(9'h101); send(9'h101); send(9'h101); send(9'h101);
`ifdef DIFF_ACC_SATURATE_EN
    expect_block("t2n", 16'hFC04, 1'b0, 10'h200, 1'b1);
`else
    expect_block("t2n", 16'hFC04, 1'b0, 10'h004, 1'b1);
`endif
    pop("t2n");

    // Test 3: back-pressure for 5 cycles with a sample waiting
    send(9'd1); send(9'd2); send(9'd3); send(9'd4);
    expect_block("t3", 16'd10, 1'b0, 10'd10, 1'b0);
    in_diff = 9'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_ready", {31'd0, in_ready16},  32'd0);
      check("t3_hold_sum",   {16'd0, out_sum16},   32'd10);
      check("t3_hold_valid", {31'd0, out_valid16}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_hs_valid", {31'd0, out_valid16}, 32'd0);
    check("t3_hs_ready", {31'd0, in_ready16},  32'd1);
    tick();
    in_valid = 1'b0;
    send(9'd1); send(9'd1); send(9'd1);
    expect_block("t3b", 16'd8, 1'b0, 10'd8, 1'b0);
    pop("t3b");

    // Test 4: asynchronous reset mid-cycle discards a partial block
    send(9'd7); send(9'd7);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_valid", {31'd0, out_valid16}, 32'd0);
    check("t4_rst_sum",   {16'd0, out_sum16},   32'd0);
    check("t4_rst_ovf",   {31'd0, out_ovf16},   32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("t4_in_ready", {31'd0, in_ready16}, 32'd1);
    send(9'd1); send(9'd1); send(9'd1); send(9'd1);
    expect_block("t4", 16'd4, 1'b0, 10'd4, 1'b0);
    pop("t4");

    // Test 5: clear during accumulation drops the partial block and the presented sample
    send(9'd100); send(9'd100);
    clear = 1'b1; in_diff = 9'd100; in_valid = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("t5_clr_valid", {31'd0, out_valid16}, 32'd0);
    check("t5_clr_ready", {31'd0, in_ready16},  32'd1);
    send(9'd1); send(9'd2); send(9'd3); send(9'd4);
    expect_block("t5", 16'd10, 1'b0, 10'd10, 1'b0);
    // clear during OUTPUT drops out_valid but keeps out_sum
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_out_clr_valid", {31'd0, out_valid16}, 32'd0);
    check("t5_out_clr_sum",   {16'd0, out_sum16},   32'd10);
    check("t5_out_clr_ready", {31'd0, in_ready16},  32'd1);

    // Test 6: random Subtractor-style stream against an integer reference
    for (int blk = 0; blk < 100; blk++) begin
      acc16 = 0; acc10 = 0; ovb16 = 1'b0; ovb10 = 1'b0;
      for (int s = 0; s < 4; s++) begin
        repeat ($urandom_range(0, 2)) tick();
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        x = a - b;
        acc16 = ref_add(acc16, x, -32768, 32767, ov); ovb16 |= ov;
        acc10 = ref_add(acc10, x, -512, 511, ov);     ovb10 |= ov;
        send(9'(x));
      end
      e16 = 16'(acc16);
      e10 = 10'(acc10);
      expect_block("t6", e16, ovb16, e10, ovb10);
      in_diff = 9'(int'($urandom_range(0, 511)));
      in_valid = 1'b1;
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("t6_pop_valid", {31'd0, out_valid16}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
